// File: rtl/darksimv_mon_fifo_if.sv
// Signal bundle between the DarkRISCV core-bus tap, the capture FIFO and the draining monitor.
// Handshake: the head record transfers on a CLK rising edge with VALID=1 and POP=1; POP with VALID=0 is ignored.
interface darksimv_mon_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    // core bus, sampled by the capture side
    logic          HLT;
    logic [31:0]   IDATA;
    logic [31:0]   IADDR;
    logic [31:0]   DATAI;
    logic [31:0]   DATAO;
    logic [31:0]   DADDR;
    logic [2:0]    DLEN;
    logic          DRD;
    logic          DWR;

    // consumer side
    logic          POP;
    logic          CLR;
    logic          VALID;
    logic [31:0]   R_IDATA;
    logic [31:0]   R_IADDR;
    logic [31:0]   R_DATAI;
    logic [31:0]   R_DATAO;
    logic [31:0]   R_DADDR;
    logic [2:0]    R_DLEN;
    logic          R_DRD;
    logic          R_DWR;
    logic [31:0]   R_CYC;
    logic [CW-1:0] COUNT;
    logic          OVF;
    logic [15:0]   DROPS;

    modport slave (
        input  HLT, IDATA, IADDR, DATAI, DATAO, DADDR, DLEN, DRD, DWR, POP, CLR,
        output VALID, R_IDATA, R_IADDR, R_DATAI, R_DATAO, R_DADDR, R_DLEN, R_DRD, R_DWR,
        output R_CYC, COUNT, OVF, DROPS
    );

    modport master (
        output HLT, IDATA, IADDR, DATAI, DATAO, DADDR, DLEN, DRD, DWR, POP, CLR,
        input  VALID, R_IDATA, R_IADDR, R_DATAI, R_DATAO, R_DADDR, R_DLEN, R_DRD, R_DWR,
        input  R_CYC, COUNT, OVF, DROPS
    );
endinterface

// File: rtl/darksimv_mon_fifo.sv
// Timestamped capture of DarkRISCV core-bus cycles into a first-word-fall-through FIFO.
// A full FIFO keeps its oldest records; rejected captures set OVF and bump a saturating DROPS counter.
module darksimv_mon_fifo #(
    parameter int DEPTH     = 16,
    parameter bit DATA_ONLY = 1'b0
) (
    input  logic               CLK,
    input  logic               RES,
    darksimv_mon_fifo_if.slave bus
);
    localparam int            AW         = $clog2(DEPTH);
    localparam int            CW         = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [15:0]   DROPS_MAX  = 16'hFFFF;

    typedef struct packed {
        logic [31:0] iaddr;
        logic [31:0] idata;
        logic [31:0] daddr;
        logic [31:0] datai;
        logic [31:0] datao;
        logic [2:0]  dlen;
        logic        drd;
        logic        dwr;
        logic [31:0] cyc;
    } rec_t;

    rec_t          mem [DEPTH];
    rec_t          rec_in;
    rec_t          head;
    rec_t          shown;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   cyc;
    logic          ovf;
    logic [15:0]   drops;
    logic          push;
    logic          pop_ok;
    logic          accept;
    logic          drop;
    logic          empty;
    logic          full;

    // A pop on a full FIFO frees the slot the same-edge push lands in, so nothing is dropped.
    always_comb begin
        push   = !bus.HLT && (!DATA_ONLY || bus.DRD || bus.DWR);
        empty  = (count == '0);
        full   = (count == FULL_COUNT);
        pop_ok = bus.POP && !empty;
        accept = push && (!full || pop_ok);
        drop   = push && !accept;
    end

    always_comb begin
        rec_in       = '0;
        rec_in.iaddr = bus.IADDR;
        rec_in.idata = bus.IDATA;
        rec_in.daddr = bus.DADDR;
        rec_in.datai = bus.DATAI;
        rec_in.datao = bus.DATAO;
        rec_in.dlen  = bus.DLEN;
        rec_in.drd   = bus.DRD;
        rec_in.dwr   = bus.DWR;
        rec_in.cyc   = cyc;
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            cyc    <= '0;
        end else begin
            cyc <= cyc + 32'd1;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset; the pointers alone define what is live.
    always_ff @(posedge CLK) begin
        if (accept) mem[wr_ptr] <= rec_in;
    end

    // CLR outranks a same-edge drop, so that drop is never counted.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            ovf   <= 1'b0;
            drops <= '0;
        end else if (bus.CLR) begin
            ovf   <= 1'b0;
            drops <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (drops != DROPS_MAX) drops <= drops + 16'd1;
        end
    end

    assign head  = mem[rd_ptr];
    assign shown = empty ? '0 : head;

    assign bus.VALID   = !empty;
    assign bus.R_IADDR = shown.iaddr;
    assign bus.R_IDATA = shown.idata;
    assign bus.R_DADDR = shown.daddr;
    assign bus.R_DATAI = shown.datai;
    assign bus.R_DATAO = shown.datao;
    assign bus.R_DLEN  = shown.dlen;
    assign bus.R_DRD   = shown.drd;
    assign bus.R_DWR   = shown.dwr;
    assign bus.R_CYC   = shown.cyc;
    assign bus.COUNT   = count;
    assign bus.OVF     = ovf;
    assign bus.DROPS   = drops;
endmodule
